waveform_meter: RTL and testbench
=================================

Name: waveform_meter

Overview:
- Measurement block on the consuming side of the signal generator's 32-bit sample stream.
- Captures one gate window of GATE_LEN accepted samples and reports min, max, the rising threshold-crossing count, and the sample-index span between the first and last rising crossing. Software derives period and frequency from these values.
- Sits between the generator or ADC sample path and the control/readout logic, so the team can check generated waveforms in-system.

Parameters:
- WIDTH, 32, sample width; samples are unsigned.
- GATE_LEN, 1024, samples per measurement window; range 2..65535.
- CNT_W, 16, width of the index and count outputs.
- THRESH, 32'h8000_0000, crossing threshold (midscale).
- HYST, 32'h0100_0000, hysteresis half-band.

Ports:
- clk in 1: single clock, rising edge.
- rst in 1: synchronous reset, active-high.
- start in 1: request a measurement; honoured only in IDLE.
- sample_valid in 1: sample qualifier.
- sample in WIDTH: input sample.
- busy out 1: high in ARM and MEASURE.
- result_valid out 1: results available; held until accepted.
- result_ready in 1: consumer accepts results.
- min_out out WIDTH: smallest sample in the window.
- max_out out WIDTH: largest sample in the window.
- rise_count out CNT_W: number of low-to-high crossings, saturating.
- first_idx out CNT_W: index of the first rising crossing.
- span out CNT_W: last rise index minus first rise index.

Behaviour:
- Reset: state=IDLE; busy=0, result_valid=0; min_out, max_out, rise_count, first_idx, span all 0. A synchronous rst in any state overrides every other input and aborts any measurement in progress.
- Thresholds are elaboration-time constants:
  - HI_TH = THRESH+HYST, saturated at all-ones.
  - LO_TH = THRESH-HYST, saturated at 0.
- FSM IDLE: if start, go to ARM. Output registers keep their last values.
- FSM ARM: on the first sample with sample_valid:
  - min=max=sample; idx=1.
  - level = (sample >= THRESH).
  - go to MEASURE.
  - No crossing can be counted on this first sample.
- FSM MEASURE: for each valid sample:
  - Update min/max.
  - Hysteresis detector: if level=0 and sample>=HI_TH, set level=1 and count a rise. If level=1 and sample<LO_TH, set level=0. Samples inside the band hold the level.
  - On a rise:
    - rise_cnt increments, saturating at all-ones.
    - If this is the first rise, first_r=idx.
    - last_r=idx on every rise.
  - idx increments on each valid sample.
  - When the accepted sample is number GATE_LEN (idx==GATE_LEN-1 before the increment), latch the outputs and go to HOLD. That final sample is included in the results.
- Output latch:
  - min_out, max_out and rise_count take the accumulated values.
  - first_idx = first_r if at least one rise occurred, else 0.
  - span = last_r-first_r if rise_count>=2, else 0.
- FSM HOLD:
  - result_valid=1 and all outputs stable.
  - On result_ready: result_valid drops the next cycle and the FSM returns to IDLE.
  - start and sample_valid are ignored in HOLD.
- Latency: result_valid rises exactly 1 cycle after the clock that accepts the final sample.
- Stall behaviour: sample_valid=0 holds all state; gaps do not advance idx.
- Wrap-around: a sawtooth going from 0xFFFF_FFFF to 0 produces a falling transition only, never a rise.
- start arriving on the same cycle as result_ready in HOLD is ignored; the FSM goes to IDLE.

Decomposition:
- Shared package waveform_meter_pkg holds:
  - the FSM state enum (IDLE, ARM, MEASURE, HOLD);
  - helper functions computing HI_TH and LO_TH with saturation.
- One sub-module, threshold_detector: registered hysteresis comparator.
  - Inputs: init, init_level, valid, sample.
  - Outputs: level, rise pulse.
  - Instantiated once.

Test Plan:
- Sawtooth, adder 0x0100_0000, start, sample_valid every cycle, GATE_LEN=1024 -> min=0, max=0xFF00_0000, rise_count=4 (indices 129, 385, 641, 897), first_idx=129, span=768, i.e. period 256.
- Constant 0x8000_0000 for 1024 samples -> level starts at 1, rise_count=0, first_idx=0, span=0, min=max=0x8000_0000.
- Chatter alternating 0x8080_0000 and 0x7F80_0000 (inside the band) -> rise_count=0. Then a step to 0x7E00_0000 followed by 0x8200_0000 -> exactly 1 rise.
- Sawtooth as in the first case with sample_valid on every 3rd cycle -> identical results; result_valid high exactly 1 cycle after the 1024th accepted sample.
- HOLD with result_ready=0 for 10 cycles while pulsing start and sample_valid -> outputs unchanged. Then result_ready=1 -> the following cycle shows result_valid=0 and IDLE; a new start re-arms.
- rst asserted mid-MEASURE at idx=500 -> next cycle busy=0, result_valid=0, all outputs 0. A subsequent start with the sawtooth gives the first-case results.

Source files
------------

// File: rtl/waveform_meter_pkg.sv
// Shared types and elaboration-time helpers for the waveform meter.
package waveform_meter_pkg;

    // Measurement sequencer states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    // Helpers work on a 64-bit container so any sample width up to 64 fits.
    localparam int MAX_W = 64;

    // Upper hysteresis threshold: thresh + hyst, clamped to the all-ones value of a w-bit sample.
    function automatic logic [MAX_W-1:0] hi_threshold(input logic [MAX_W-1:0] thresh,
                                                      input logic [MAX_W-1:0] hyst,
                                                      input int unsigned      w);
        logic [MAX_W:0] sum;
        logic [MAX_W:0] lim;
        sum = {1'b0, thresh} + {1'b0, hyst};
        lim = ({{MAX_W{1'b0}}, 1'b1} << w) - 1'b1;
        return (sum > lim) ? lim[MAX_W-1:0] : sum[MAX_W-1:0];
    endfunction

    // Lower hysteresis threshold: thresh - hyst, clamped at zero.
    function automatic logic [MAX_W-1:0] lo_threshold(input logic [MAX_W-1:0] thresh,
                                                      input logic [MAX_W-1:0] hyst);
        return (hyst > thresh) ? '0 : (thresh - hyst);
    endfunction

endpackage

// File: rtl/waveform_meter_threshold_detector.sv
// Registered hysteresis comparator. The level is held in a flop; the rise
// pulse is decoded from the held level and the current sample so the caller
// sees the crossing in the same cycle the sample is accepted.
module threshold_detector #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] HI_TH = 32'h8100_0000,
    parameter logic [WIDTH-1:0] LO_TH = 32'h7F00_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic             init_level,
    input  logic             valid,
    input  logic [WIDTH-1:0] sample,
    output logic             level,
    output logic             rise
);

    logic level_r;

    assign level = level_r;
    // A rise needs a low level and a sample at or above the upper band edge.
    assign rise  = valid && !init && !level_r && (sample >= HI_TH);

    // Level tracks the signal; samples inside the band leave it unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_r <= 1'b0;
        end else if (init) begin
            level_r <= init_level;
        end else if (valid) begin
            if (!level_r && (sample >= HI_TH)) begin
                level_r <= 1'b1;
            end else if (level_r && (sample < LO_TH)) begin
                level_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/waveform_meter.sv
// Gate-window waveform meter: captures GATE_LEN accepted samples and reports
// min, max, rising-crossing count, first rise index and first-to-last span.
// Results are held with result_valid until result_ready is seen.
module waveform_meter
    import waveform_meter_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               GATE_LEN = 1024,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] THRESH   = 32'h8000_0000,
    parameter logic [WIDTH-1:0] HYST     = 32'h0100_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_valid,
    input  logic [WIDTH-1:0] sample,
    output logic             busy,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [WIDTH-1:0] min_out,
    output logic [WIDTH-1:0] max_out,
    output logic [CNT_W-1:0] rise_count,
    output logic [CNT_W-1:0] first_idx,
    output logic [CNT_W-1:0] span
);

    localparam logic [WIDTH-1:0] HI_TH    = WIDTH'(hi_threshold(MAX_W'(THRESH), MAX_W'(HYST), WIDTH));
    localparam logic [WIDTH-1:0] LO_TH    = WIDTH'(lo_threshold(MAX_W'(THRESH), MAX_W'(HYST)));
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(GATE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);

    state_t           state;
    logic [WIDTH-1:0] min_acc;
    logic [WIDTH-1:0] max_acc;
    logic [CNT_W-1:0] cnt_acc;
    logic [CNT_W-1:0] first_r;
    logic [CNT_W-1:0] last_r;
    logic [CNT_W-1:0] idx;

    logic             det_init;
    logic             det_valid;
    logic             det_level;
    logic             det_rise;

    logic [WIDTH-1:0] min_n;
    logic [WIDTH-1:0] max_n;
    logic [CNT_W-1:0] cnt_n;
    logic [CNT_W-1:0] first_n;
    logic [CNT_W-1:0] last_n;

    assign det_init  = (state == ARM) && sample_valid;
    assign det_valid = (state == MEASURE) && sample_valid;

    threshold_detector #(
        .WIDTH (WIDTH),
        .HI_TH (HI_TH),
        .LO_TH (LO_TH)
    ) u_det (
        .clk        (clk),
        .rst        (rst),
        .init       (det_init),
        .init_level (sample >= THRESH),
        .valid      (det_valid),
        .sample     (sample),
        .level      (det_level),
        .rise       (det_rise)
    );

    // Accumulator values including the current sample, used both to update
    // the running state and to latch the final sample into the results.
    always_comb begin
        min_n   = (sample < min_acc) ? sample : min_acc;
        max_n   = (sample > max_acc) ? sample : max_acc;
        cnt_n   = cnt_acc;
        first_n = first_r;
        last_n  = last_r;
        if (det_rise) begin
            if (cnt_acc != CNT_MAX) begin
                cnt_n = cnt_acc + 1'b1;
            end
            // The count saturates but never returns to zero, so zero means no rise yet.
            if (cnt_acc == '0) begin
                first_n = idx;
            end
            last_n = idx;
        end
    end

    // Sequencer, accumulators and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            min_acc      <= '0;
            max_acc      <= '0;
            cnt_acc      <= '0;
            first_r      <= '0;
            last_r       <= '0;
            idx          <= '0;
            min_out      <= '0;
            max_out      <= '0;
            rise_count   <= '0;
            first_idx    <= '0;
            span         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ARM;
                        busy  <= 1'b1;
                    end
                end
                ARM: begin
                    if (sample_valid) begin
                        min_acc <= sample;
                        max_acc <= sample;
                        cnt_acc <= '0;
                        first_r <= '0;
                        last_r  <= '0;
                        idx     <= CNT_W'(1);
                        state   <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (sample_valid) begin
                        min_acc <= min_n;
                        max_acc <= max_n;
                        cnt_acc <= cnt_n;
                        first_r <= first_n;
                        last_r  <= last_n;
                        idx     <= idx + 1'b1;
                        if (idx == LAST_IDX) begin
                            min_out      <= min_n;
                            max_out      <= max_n;
                            rise_count   <= cnt_n;
                            first_idx    <= (cnt_n != '0) ? first_n : '0;
                            span         <= (cnt_n >= CNT_TWO) ? (last_n - first_n) : '0;
                            state        <= HOLD;
                            busy         <= 1'b0;
                            result_valid <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (result_ready) begin
                        result_valid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_waveform_meter.sv
// Directed bench for waveform_meter: gate windows of known waveforms, with
// expected results queued at stimulus time and compared when results appear.
module tb_waveform_meter;

    localparam int N = 1024;

    typedef struct packed {
        logic [31:0] mn;
        logic [31:0] mx;
        logic [15:0] cnt;
        logic [15:0] first;
        logic [15:0] span;
    } res_t;

    localparam res_t SAW_EXP   = '{mn: 32'h0000_0000, mx: 32'hFF00_0000, cnt: 16'd4, first: 16'd129,  span: 16'd768};
    localparam res_t CONST_EXP = '{mn: 32'h8000_0000, mx: 32'h8000_0000, cnt: 16'd0, first: 16'd0,    span: 16'd0};
    localparam res_t CHAT_EXP  = '{mn: 32'h7F80_0000, mx: 32'h8080_0000, cnt: 16'd0, first: 16'd0,    span: 16'd0};
    localparam res_t STEP_EXP  = '{mn: 32'h7E00_0000, mx: 32'h8200_0000, cnt: 16'd1, first: 16'd1001, span: 16'd0};

    logic        clk;
    logic        rst;
    logic        start;
    logic        sample_valid;
    logic [31:0] sample;
    logic        busy;
    logic        result_valid;
    logic        result_ready;
    logic [31:0] min_out;
    logic [31:0] max_out;
    logic [15:0] rise_count;
    logic [15:0] first_idx;
    logic [15:0] span;

    res_t exp_q[$];
    res_t cur;
    int   checks;
    int   failures;

    waveform_meter dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sample_valid (sample_valid),
        .sample       (sample),
        .busy         (busy),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .min_out      (min_out),
        .max_out      (max_out),
        .rise_count   (rise_count),
        .first_idx    (first_idx),
        .span         (span)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [31:0] gen(input int kind, input int k);
        logic [31:0] v;
        v = 32'h0;
        case (kind)
            0: v = 32'(k) << 24;
            1: v = 32'h8000_0000;
            2: begin
                if (k < 1000)       v = k[0] ? 32'h7F80_0000 : 32'h8080_0000;
                else if (k == 1000) v = 32'h7E00_0000;
                else                v = 32'h8200_0000;
            end
            default: v = k[0] ? 32'h7F80_0000 : 32'h8080_0000;
        endcase
        return v;
    endfunction

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic drive_sample(input logic [31:0] v, input int gap);
        sample_valid = 1'b1;
        sample       = v;
        @(posedge clk);
        #1 sample_valid = 1'b0;
        sample = $urandom;
        repeat (gap) @(posedge clk);
        #1;
    endtask

    // Drives one full window; checks result_valid latency around the last sample.
    task automatic run_window(input int kind, input int gap);
        do_start();
        for (int k = 0; k < N; k++) begin
            if (k == N - 1) begin
                chk("rv_before_last", 32'(result_valid), 32'd0);
                drive_sample(gen(kind, k), 0);
                chk("rv_latency", 32'(result_valid), 32'd1);
                chk("busy_done", 32'(busy), 32'd0);
                repeat (gap) @(posedge clk);
                #1;
            end else begin
                drive_sample(gen(kind, k), gap);
            end
        end
    endtask

    task automatic check_results(input string tag);
        int waited;
        waited = 0;
        while (result_valid !== 1'b1 && waited < 8) begin
            @(posedge clk);
            #1 waited++;
        end
        chk({tag, "_rv"}, 32'(result_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 32'd0, 32'd1);
            cur = '0;
        end else begin
            cur = exp_q.pop_front();
        end
        chk({tag, "_min"},   min_out,           cur.mn);
        chk({tag, "_max"},   max_out,           cur.mx);
        chk({tag, "_cnt"},   32'(rise_count),   32'(cur.cnt));
        chk({tag, "_first"}, 32'(first_idx),    32'(cur.first));
        chk({tag, "_span"},  32'(span),         32'(cur.span));
    endtask

    task automatic release_results(input logic with_start);
        result_ready = 1'b1;
        start        = with_start;
        @(posedge clk);
        #1 result_ready = 1'b0;
        start = 1'b0;
        chk("rv_released", 32'(result_valid), 32'd0);
        chk("idle_after_release", 32'(busy), 32'd0);
        @(posedge clk);
        #1 chk("still_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        start        = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        result_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rv",   32'(result_valid), 32'd0);
        chk("rst_min",  min_out, 32'd0);
        chk("rst_max",  max_out, 32'd0);
        chk("rst_cnt",  32'(rise_count), 32'd0);
        chk("rst_first", 32'(first_idx), 32'd0);
        chk("rst_span", 32'(span), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Sawtooth, continuous samples.
        exp_q.push_back(SAW_EXP);
        run_window(0, 0);
        check_results("saw");

        // Hold with ready low while start and sample_valid toggle.
        for (int c = 0; c < 10; c++) begin
            start        = 1'($urandom_range(0, 1));
            sample_valid = 1'b1;
            sample       = $urandom;
            @(posedge clk);
            #1;
            chk("hold_rv",  32'(result_valid), 32'd1);
            chk("hold_min", min_out, cur.mn);
            chk("hold_cnt", 32'(rise_count), 32'(cur.cnt));
            chk("hold_span", 32'(span), 32'(cur.span));
        end
        start        = 1'b0;
        sample_valid = 1'b0;
        release_results(1'b1);

        // Constant midscale.
        exp_q.push_back(CONST_EXP);
        run_window(1, 0);
        check_results("const");
        release_results(1'b0);

        // Chatter inside the band.
        exp_q.push_back(CHAT_EXP);
        run_window(3, 0);
        check_results("chatter");
        release_results(1'b0);

        // Chatter, then a step out of the band and back over it.
        exp_q.push_back(STEP_EXP);
        run_window(2, 0);
        check_results("step");
        release_results(1'b0);

        // Sawtooth with a sample every third cycle.
        exp_q.push_back(SAW_EXP);
        run_window(0, 2);
        check_results("saw_gap");
        release_results(1'b0);

        // Reset in the middle of a measurement.
        do_start();
        for (int k = 0; k < 500; k++) drive_sample(gen(0, k), 0);
        chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rv",   32'(result_valid), 32'd0);
        chk("abort_min",  min_out, 32'd0);
        chk("abort_max",  max_out, 32'd0);
        chk("abort_cnt",  32'(rise_count), 32'd0);
        chk("abort_first", 32'(first_idx), 32'd0);
        chk("abort_span", 32'(span), 32'd0);

        exp_q.push_back(SAW_EXP);
        run_window(0, 0);
        check_results("saw_after_rst");
        release_results(1'b0);

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
